// File: rtl/ex_muldiv_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ex_muldiv_unit_pkg                                           |
// | Purpose : Shared M-extension op codes and multiply/divide FSM state    |
// |           encodings used by the EX-stage multiply/divide unit.         |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package ex_muldiv_unit_pkg;

  // M-extension operation codes as carried on op_i
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_unit_div_core.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ex_muldiv_unit_div_core                                      |
// | Purpose : Restoring unsigned divider datapath, one quotient bit per    |
// |           step. Operands are magnitudes; signs are handled by the top. |
// | Ports   : clk, reset_n (async, active-low)                             |
// |           load_i      - capture dividend/divisor, clear remainder      |
// |           step_i      - perform one restoring iteration                |
// |           dividend_i, divisor_i [XLEN]                                 |
// |           quotient_o, remainder_o [XLEN] - valid after XLEN steps      |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module ex_muldiv_unit_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN:0]   trial;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;
    // Partial remainder shifted left with the next dividend bit brought in
    trial  = {rem_q, quo_q[XLEN-1]};
    if (load_i) begin
      quo_d  = dividend_i;
      rem_d  = '0;
      dvsr_d = divisor_i;
    end else if (step_i) begin
      quo_d = {quo_q[XLEN-2:0], 1'b0};
      // rem_q < divisor, so a successful subtraction always fits in XLEN bits
      if (trial >= {1'b0, dvsr_q}) begin
        rem_d    = trial[XLEN-1:0] - dvsr_q;
        quo_d[0] = 1'b1;
      end else begin
        rem_d = trial[XLEN-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ex_muldiv_unit                                               |
// | Purpose : Iterative RV32M multiply/divide unit for the EX stage.       |
// |           Multiply: radix-2 shift-add, 32 iterations.                  |
// |           Divide  : restoring division on magnitudes plus sign fix-up, |
// |                     present only when MULDIV_DIV_EN is defined;        |
// |                     otherwise divide ops complete with result 0.       |
// | Ports   : clk, reset_n (async, active-low)                             |
// |           start_i, op_i[3], op_a_i/op_b_i[XLEN], flush_i               |
// |           busy_o (stall), valid_o (1-cycle pulse), result_o[XLEN]      |
// | Config  : MULDIV_DIV_EN - include the divider                          |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  md_state_e         state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              b_signed_q, b_signed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;       // result of the op currently finishing
  logic [XLEN-1:0]   result_q, result_d; // last result delivered with valid_o

  logic              a_sext, b_sext;
  logic [2*XLEN-1:0] partial;

`ifdef MULDIV_DIV_EN
  logic            fast_q, fast_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            div_load, div_step;
  logic            div_signed, a_neg, b_neg;
  logic [XLEN-1:0] div_dividend, div_divisor;
  logic [XLEN-1:0] div_quo, div_rem;

  ex_muldiv_unit_div_core #(.XLEN(XLEN)) u_div_core (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (div_dividend),
    .divisor_i   (div_divisor),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    b_signed_d = b_signed_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    result_d   = result_q;
    busy_o     = 1'b0;
    valid_o    = 1'b0;
    a_sext     = 1'b0;
    b_sext     = 1'b0;
    partial    = '0;
`ifdef MULDIV_DIV_EN
    fast_d       = fast_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    div_load     = 1'b0;
    div_step     = 1'b0;
    div_signed   = (op_i == MD_DIV) || (op_i == MD_REM);
    a_neg        = div_signed && op_a_i[XLEN-1];
    b_neg        = div_signed && op_b_i[XLEN-1];
    div_dividend = a_neg ? -op_a_i : op_a_i;
    div_divisor  = b_neg ? -op_b_i : op_b_i;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          busy_o = 1'b1;
          op_d   = op_i;
          cnt_d  = '0;
          acc_d  = '0;
          if (!md_is_div(op_i)) begin
            a_sext     = (op_i != MD_MULHU);
            b_sext     = (op_i == MD_MUL) || (op_i == MD_MULH);
            mcand_d    = {{XLEN{a_sext & op_a_i[XLEN-1]}}, op_a_i};
            mplier_d   = op_b_i;
            b_signed_d = b_sext;
            state_d    = ST_MUL;
          end else begin
`ifdef MULDIV_DIV_EN
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            if (op_b_i == '0) begin
              fast_d  = 1'b1;
              res_d   = ((op_i == MD_REM) || (op_i == MD_REMU)) ? op_a_i : '1;
              state_d = ST_FIX;
            end else if (div_signed && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                         (op_b_i == '1)) begin
              // Signed overflow: quotient saturates to the dividend itself
              fast_d  = 1'b1;
              res_d   = (op_i == MD_REM) ? '0 : op_a_i;
              state_d = ST_FIX;
            end else begin
              fast_d   = 1'b0;
              div_load = 1'b1;
              state_d  = ST_DIV;
            end
`else
            res_d   = '0;
            state_d = ST_FIX;
`endif
          end
        end
      end

      ST_MUL: begin
        busy_o = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          partial = mplier_q[0] ? mcand_q : '0;
          // A signed multiplier's top bit carries weight -2^(XLEN-1)
          if ((cnt_q == CNT_LAST) && b_signed_q) begin
            acc_d = acc_q - partial;
          end else begin
            acc_d = acc_q + partial;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            res_d   = (op_q == MD_MUL) ? acc_d[XLEN-1:0] : acc_d[2*XLEN-1:XLEN];
            state_d = ST_DONE;
          end
        end
      end

`ifdef MULDIV_DIV_EN
      ST_DIV: begin
        busy_o = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          div_step = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_FIX;
          end
        end
      end
`endif

      ST_FIX: begin
        busy_o = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
`ifdef MULDIV_DIV_EN
          if (!fast_q) begin
            if ((op_q == MD_REM) || (op_q == MD_REMU)) begin
              res_d = neg_rem_q ? -div_rem : div_rem;
            end else begin
              res_d = neg_quo_q ? -div_quo : div_quo;
            end
          end
`endif
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        valid_o = !flush_i;
        if (!flush_i) begin
          result_d = res_q;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // The finishing result is presented in the DONE cycle itself; a flush in
  // that cycle keeps the previously delivered value on the output.
  assign result_o = ((state_q == ST_DONE) && !flush_i) ? res_q : result_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      b_signed_q <= 1'b0;
      cnt_q      <= '0;
      res_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      b_signed_q <= b_signed_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      result_q   <= result_d;
    end
  end

`ifdef MULDIV_DIV_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fast_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      fast_q    <= fast_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_ex_muldiv_unit                                            |
// | Purpose : Self-checking bench for ex_muldiv_unit: directed corner      |
// |           cases plus randomized ops against an arithmetic model.       |
// |           Divide expectations follow MULDIV_DIV_EN.                    |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        flush_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] hold;   // value result_o must show between valid pulses

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: RV32M semantics with plain integer arithmetic.
  // op codes: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          si, sj;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    si = a;
    sj = b;
    r  = '0;
    lat = 33;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          lat = 2;
          r   = (op == 3'd6 || op == 3'd7) ? a : 32'hFFFF_FFFF;
        end else if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lat = 2;
          r   = (op == 3'd6) ? 32'd0 : 32'h8000_0000;
        end else begin
          lat = 34;
          case (op)
            3'd4:    r = si / sj;
            3'd5:    r = a / b;
            3'd6:    r = si % sj;
            default: r = a % b;
          endcase
        end
`else
        lat = 2;
        r   = 32'd0;
`endif
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // mode: 0 plain, 1 extra start_i at cycle 5, 2 extra start at 5 + flush at 10,
  //       3 flush in the DONE cycle. Entered and left just after a rising edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int mode);
    logic [31:0] exp;
    int          lat, n, gaps, nv, m;
    bit          seen;
    model(op, a, b, exp, lat);
    m = (mode != 3 && lat <= 10) ? 0 : mode;
    op_i = op; op_a_i = a; op_b_i = b; start_i = 1'b1;
    #1;
    check_value("busy_accept", 32'(busy_o), 32'd1);
    n = 0; gaps = 0; seen = 0;
    while (!seen && n < 45) begin
      @(posedge clk); #1;
      n++;
      start_i = 1'b0;
      if ((m == 1 || m == 2) && n == 5) begin
        start_i = 1'b1; op_i = ~op; op_a_i = $urandom; op_b_i = $urandom;
      end
      if (m == 2 && n == 10) begin
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check_value("flush_busy", 32'(busy_o), 32'd0);
        nv = 0;
        repeat (40) begin
          if (valid_o) nv++;
          @(posedge clk); #1;
        end
        check_value("flush_no_valid", nv, 0);
        check_value("flush_hold", result_o, hold);
        return;
      end
      if (m == 3 && n == lat) begin
        check_value("done_valid_pre", 32'(valid_o), 32'd1);
        flush_i = 1'b1;
        #1;
        check_value("done_flush_valid", 32'(valid_o), 32'd0);
        check_value("done_flush_hold", result_o, hold);
        @(posedge clk); #1;
        flush_i = 1'b0;
        check_value("done_flush_idle", 32'(busy_o | valid_o), 32'd0);
        check_value("done_flush_hold2", result_o, hold);
        return;
      end
      if (valid_o) seen = 1;
      else if (!busy_o) gaps++;
    end
    check_value($sformatf("latency op%0d", op), n, lat);
    check_value($sformatf("result op%0d a=%08h b=%08h", op, a, b), result_o, exp);
    check_value("busy_gaps", gaps, 0);
    check_value("busy_done", 32'(busy_o), 32'd0);
    hold = exp;
    @(posedge clk); #1;
    check_value("valid_pulse", 32'(valid_o), 32'd0);
    check_value("result_hold", result_o, hold);
  endtask

  task automatic reset_mid();
    int nv;
`ifdef MULDIV_DIV_EN
    op_i = 3'd4; op_a_i = 32'hFFFF_FFF9; op_b_i = 32'd2;
`else
    op_i = 3'd0; op_a_i = 32'd7; op_b_i = 32'd9;
`endif
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_value("rst_busy", 32'(busy_o), 32'd0);
    check_value("rst_valid", 32'(valid_o), 32'd0);
    check_value("rst_result", result_o, 32'd0);
    #1;
    reset_n = 1'b1;
    hold = 32'd0;
    nv = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) nv++;
    end
    check_value("rst_no_valid", nv, 0);
    check_value("rst_result_after", result_o, 32'd0);
  endtask

  initial begin
    int mode, sel;
    reset_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    op_i = '0; op_a_i = '0; op_b_i = '0; hold = '0;
    repeat (2) @(posedge clk);
    #1;
    check_value("reset_busy", 32'(busy_o), 32'd0);
    check_value("reset_valid", 32'(valid_o), 32'd0);
    check_value("reset_result", result_o, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // directed corner cases
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    check_value("mul_7x-3", result_o, 32'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd5, 32'd5, 32'd0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd7, 32'd123, 32'd0, 0);
    run_op(3'd4, 32'd9, 32'd3, 0);
    run_op(3'd0, 32'd9, 32'd3, 0);
    check_value("mul_9x3", result_o, 32'd27);
    run_op(3'd0, 32'd5, 32'd6, 2);
    run_op(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1);
    run_op(3'd1, 32'h1234_5678, 32'h8765_4321, 3);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    reset_mid();
    run_op(3'd0, 32'd3, 32'd4, 0);

    // randomized ops, back to back
    for (int i = 0; i < 40; i++) begin
      sel  = $urandom_range(0, 5);
      mode = (sel == 0) ? 3 : (sel == 1) ? 1 : 0;
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), mode);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
